// File: rtl/text_glyph_sequencer.sv
// text_glyph_sequencer
// Turns the latched custom-text character array into one glyph draw request
// per character (code, screen X, index) using a req/ack handshake with the
// glyph/overlay renderer. A run starts on a rising edge of char_array_rdy,
// and dropping char_array_rdy aborts a run in progress.
// Optional feature macro: LOWERCASE_FOLD_EN (when defined, a..z map to the
// same letter codes as A..Z; otherwise lowercase renders as blank).
module text_glyph_sequencer #(
    parameter int TEXT_LEN_MAX = 20,
    parameter int CHAR_W       = 8,
    parameter int X_W          = 11
) (
    input  logic                      clock_27mhz,
    input  logic                      reset,
    input  logic [TEXT_LEN_MAX*8-1:0] char_array,
    input  logic                      char_array_rdy,
    input  logic [5:0]                num_char,
    input  logic [X_W-1:0]            x_origin,
    input  logic                      glyph_ack,
    output logic                      glyph_req,
    output logic [4:0]                glyph_code,
    output logic [X_W-1:0]            glyph_x,
    output logic [5:0]                glyph_idx,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        WAIT_ACK,
        FIN
    } state_t;

    localparam int             TEXT_W = TEXT_LEN_MAX * 8;
    localparam logic [5:0]     N_MAX  = 6'(TEXT_LEN_MAX);
    localparam logic [X_W-1:0] X_STEP = X_W'(CHAR_W);
    localparam logic [4:0]     BLANK  = 5'd26;

    state_t             state;
    logic               rdy_prev;
    logic [TEXT_W-1:0]  text_snap;
    logic [X_W-1:0]     x_next;
    logic [5:0]         n_chars;
    logic               rdy_rise;

    // ASCII byte to 5-bit letter code; anything that is not a letter is blank.
    function automatic logic [4:0] ascii_to_code(input logic [7:0] b);
        logic [4:0] c;
        c = BLANK;
        if (b >= 8'h41 && b <= 8'h5A) begin
            c = 5'(b - 8'h41);
        end
`ifdef LOWERCASE_FOLD_EN
        else if (b >= 8'h61 && b <= 8'h7A) begin
            c = 5'(b - 8'h61);
        end
`else
        else begin
            c = BLANK;
        end
`endif
        return c;
    endfunction

    assign rdy_rise = char_array_rdy & ~rdy_prev;

    // Sequencer FSM: snapshot the text, then walk it one character per
    // handshake. The snapshot is shifted left after each ack so the current
    // character always sits in the top byte, and X advances by one pitch per
    // character, wrapping naturally at the X_W-bit width.
    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            state      <= IDLE;
            rdy_prev   <= 1'b0;
            text_snap  <= '0;
            x_next     <= '0;
            n_chars    <= '0;
            glyph_req  <= 1'b0;
            glyph_code <= '0;
            glyph_x    <= '0;
            glyph_idx  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rdy_prev <= char_array_rdy;
            done     <= 1'b0;
            if (state != IDLE && !char_array_rdy) begin
                state     <= IDLE;
                glyph_req <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rdy_rise) begin
                            state <= LATCH;
                        end
                    end
                    LATCH: begin
                        text_snap <= char_array;
                        x_next    <= x_origin;
                        n_chars   <= (num_char > N_MAX) ? N_MAX : num_char;
                        glyph_idx <= '0;
                        busy      <= 1'b1;
                        state     <= (num_char == 6'd0) ? FIN : ISSUE;
                    end
                    ISSUE: begin
                        glyph_req  <= 1'b1;
                        glyph_code <= ascii_to_code(text_snap[TEXT_W-1 -: 8]);
                        glyph_x    <= x_next;
                        state      <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (glyph_ack) begin
                            glyph_req <= 1'b0;
                            glyph_idx <= glyph_idx + 6'd1;
                            text_snap <= text_snap << 8;
                            x_next    <= x_next + X_STEP;
                            state     <= (glyph_idx + 6'd1 == n_chars) ? FIN : ISSUE;
                        end
                    end
                    FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
